// File: rtl/eth_parser_pkg.sv
`default_nettype none
//==============================================================================
// Module   : eth_parser_pkg
// Desc     : Shared types and constants for the Ethernet header extractor.
// Revision : 1.0 - initial release
//==============================================================================
package eth_parser_pkg;

    localparam logic [15:0] TPID_VLAN     = 16'h8100;
    localparam int          HDR_BUF_BYTES = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SKIP = 2'd2
    } eth_state_t;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic        vlan_valid;
        logic [15:0] tci;
        logic [15:0] ethertype;
    } eth_hdr_t;

    // Byte n of the header buffer sits at bits [8n+7:8n].
    function automatic logic [7:0] hdr_byte(input logic [HDR_BUF_BYTES*8-1:0] b,
                                            input logic [4:0]                 n);
        return b[{n, 3'b000} +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_hdr_decode.sv
`default_nettype none
//==============================================================================
// Module   : eth_hdr_decode
// Desc     : Combinational decode of a 24-byte header buffer into MAC/VLAN/type.
// Revision : 1.0 - initial release
//==============================================================================
module eth_hdr_decode
    import eth_parser_pkg::*;
(
    input  logic [HDR_BUF_BYTES*8-1:0] hdr_bytes,
    output eth_hdr_t                   hdr
);

    logic [15:0] w_tpid;
    logic [47:0] w_unused_tail;

    assign w_unused_tail = hdr_bytes[191:144];
    assign w_tpid        = {hdr_byte(hdr_bytes, 5'd12), hdr_byte(hdr_bytes, 5'd13)};

    always_comb begin
        hdr.dst = {hdr_byte(hdr_bytes, 5'd0), hdr_byte(hdr_bytes, 5'd1),
                   hdr_byte(hdr_bytes, 5'd2), hdr_byte(hdr_bytes, 5'd3),
                   hdr_byte(hdr_bytes, 5'd4), hdr_byte(hdr_bytes, 5'd5)};
        hdr.src = {hdr_byte(hdr_bytes, 5'd6),  hdr_byte(hdr_bytes, 5'd7),
                   hdr_byte(hdr_bytes, 5'd8),  hdr_byte(hdr_bytes, 5'd9),
                   hdr_byte(hdr_bytes, 5'd10), hdr_byte(hdr_bytes, 5'd11)};
        hdr.vlan_valid = 1'b0;
        hdr.tci        = 16'h0000;
        hdr.ethertype  = w_tpid;
        if (w_tpid == TPID_VLAN) begin
            hdr.vlan_valid = 1'b1;
            hdr.tci        = {hdr_byte(hdr_bytes, 5'd14), hdr_byte(hdr_bytes, 5'd15)};
            hdr.ethertype  = {hdr_byte(hdr_bytes, 5'd16), hdr_byte(hdr_bytes, 5'd17)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_hdr_extract.sv
`default_nettype none
//==============================================================================
// Module   : eth_hdr_extract
// Desc     : Captures the first header beats of each frame and presents the
//            decoded Ethernet/802.1Q header on a valid/ready output.
// Config   : define ETH_HDR_STATS_EN to enable frame/runt statistics counters.
// Revision : 1.0 - initial release
//==============================================================================
module eth_hdr_extract
    import eth_parser_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int HEADER_BYTES = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic                  frame_start,
    output logic                  in_header,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [47:0]           hdr_dst_mac,
    output logic [47:0]           hdr_src_mac,
    output logic                  hdr_vlan_valid,
    output logic [15:0]           hdr_vlan_tci,
    output logic [15:0]           hdr_ethertype,
    output logic                  err_runt,
    output logic [31:0]           stat_frames,
    output logic [31:0]           stat_runts
);

    localparam int         c_beat_bytes = DATA_WIDTH / 8;
    localparam int         c_hdr_beats  = (HEADER_BYTES + c_beat_bytes - 1) / c_beat_bytes;
    localparam logic [1:0] c_last_beat  = 2'(c_hdr_beats - 1);

    eth_state_t                r_state;
    eth_state_t                w_next_state;
    logic [1:0]                r_beat_cnt;
    logic [1:0]                w_beat_cnt_next;
    logic [2*DATA_WIDTH-1:0]   r_hdr_buf;
    logic [HDR_BUF_BYTES*8-1:0] w_dec_in;
    eth_hdr_t                  w_dec_hdr;
    eth_hdr_t                  r_hdr;
    logic                      r_hdr_valid;
    logic                      r_frame_start;
    logic                      r_err_runt;
    logic                      w_accept;
    logic                      w_start;
    logic                      w_store;
    logic                      w_load;
    logic                      w_runt;

    // Stall only while a finished header waits for a free output slot.
    assign s_tready = ~rst_n | ~((r_state == ST_HDR) & r_hdr_valid & ~hdr_ready);
    assign w_accept = s_tvalid & s_tready;

    always_comb begin
        w_next_state    = r_state;
        w_beat_cnt_next = r_beat_cnt;
        w_start         = 1'b0;
        w_store         = 1'b0;
        w_load          = 1'b0;
        w_runt          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_start = 1'b1;
                    w_store = 1'b1;
                    if (s_tlast) begin
                        w_runt          = 1'b1;
                        w_beat_cnt_next = 2'd0;
                    end else begin
                        w_next_state    = ST_HDR;
                        w_beat_cnt_next = 2'd1;
                    end
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    if (r_beat_cnt == c_last_beat) begin
                        w_load          = 1'b1;
                        w_beat_cnt_next = 2'd0;
                        w_next_state    = s_tlast ? ST_IDLE : ST_SKIP;
                    end else begin
                        w_store = 1'b1;
                        if (s_tlast) begin
                            w_runt          = 1'b1;
                            w_beat_cnt_next = 2'd0;
                            w_next_state    = ST_IDLE;
                        end else begin
                            w_beat_cnt_next = r_beat_cnt + 2'd1;
                        end
                    end
                end
            end
            ST_SKIP: begin
                if (w_accept && s_tlast) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state    = ST_IDLE;
                w_beat_cnt_next = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= 2'd0;
        end else begin
            r_state    <= w_next_state;
            r_beat_cnt <= w_beat_cnt_next;
        end
    end

    // The final header beat is decoded straight from the bus, never buffered.
    assign w_dec_in = {s_tdata, r_hdr_buf};

    eth_hdr_decode u_decode (
        .hdr_bytes (w_dec_in),
        .hdr       (w_dec_hdr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hdr_buf     <= '0;
            r_hdr         <= '0;
            r_hdr_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_err_runt    <= 1'b0;
        end else begin
            r_frame_start <= w_start;
            r_err_runt    <= w_runt;
            if (w_store) begin
                if (r_beat_cnt[0]) begin
                    r_hdr_buf[2*DATA_WIDTH-1:DATA_WIDTH] <= s_tdata;
                end else begin
                    r_hdr_buf[DATA_WIDTH-1:0] <= s_tdata;
                end
            end
            if (w_load) begin
                r_hdr       <= w_dec_hdr;
                r_hdr_valid <= 1'b1;
            end else if (r_hdr_valid && hdr_ready) begin
                r_hdr_valid <= 1'b0;
            end
        end
    end

`ifdef ETH_HDR_STATS_EN
    logic [31:0] r_stat_frames;
    logic [31:0] r_stat_runts;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_frames <= 32'd0;
            r_stat_runts  <= 32'd0;
        end else begin
            if (w_load && (r_stat_frames != 32'hFFFF_FFFF)) begin
                r_stat_frames <= r_stat_frames + 32'd1;
            end
            if (w_runt && (r_stat_runts != 32'hFFFF_FFFF)) begin
                r_stat_runts <= r_stat_runts + 32'd1;
            end
        end
    end

    assign stat_frames = r_stat_frames;
    assign stat_runts  = r_stat_runts;
`else
    assign stat_frames = 32'd0;
    assign stat_runts  = 32'd0;
`endif

    assign frame_start    = r_frame_start;
    assign err_runt       = r_err_runt;
    assign in_header      = (r_state == ST_HDR);
    assign hdr_valid      = r_hdr_valid;
    assign hdr_dst_mac    = r_hdr.dst;
    assign hdr_src_mac    = r_hdr.src;
    assign hdr_vlan_valid = r_hdr.vlan_valid;
    assign hdr_vlan_tci   = r_hdr.tci;
    assign hdr_ethertype  = r_hdr.ethertype;

endmodule
`default_nettype wire

// File: tb/tb_eth_hdr_extract.sv
`default_nettype none
//==============================================================================
// Module   : tb_eth_hdr_extract
// Desc     : Self-checking bench for eth_hdr_extract: directed vector table,
//            corner-case sequences and randomized frames vs. a byte-level model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_eth_hdr_extract;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic        frame_start, in_header, hdr_valid, hdr_ready;
    logic [47:0] hdr_dst_mac, hdr_src_mac;
    logic        hdr_vlan_valid;
    logic [15:0] hdr_vlan_tci, hdr_ethertype;
    logic        err_runt;
    logic [31:0] stat_frames, stat_runts;

    always #5 clk = ~clk;

    eth_hdr_extract dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .frame_start    (frame_start),
        .in_header      (in_header),
        .hdr_valid      (hdr_valid),
        .hdr_ready      (hdr_ready),
        .hdr_dst_mac    (hdr_dst_mac),
        .hdr_src_mac    (hdr_src_mac),
        .hdr_vlan_valid (hdr_vlan_valid),
        .hdr_vlan_tci   (hdr_vlan_tci),
        .hdr_ethertype  (hdr_ethertype),
        .err_runt       (err_runt),
        .stat_frames    (stat_frames),
        .stat_runts     (stat_runts)
    );

`ifdef ETH_HDR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic        vlan;
        logic [15:0] tci;
        logic [15:0] etype;
    } hdr_t;

    typedef struct {
        string       name;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] w12;
        logic [15:0] w14;
        logic [15:0] w16;
        int          nbeats;
        bit          exp_hdr;
        logic        exp_vlan;
        logic [15:0] exp_tci;
        logic [15:0] exp_type;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    hdr_t exp_q[$];
    int   exp_starts = 0, exp_runts = 0, exp_both = 0, exp_sf = 0, exp_sr = 0;
    int   seen_starts = 0, seen_runts = 0, seen_both = 0;
    int   cyc = 0;
    int   start_cyc[$];
    logic [7:0] fb [0:47];
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] stat_exp(input int v);
        return STATS_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] w12, input logic [15:0] w14, input logic [15:0] w16);
        for (int i = 0; i < 48; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            fb[i]     = dst[47-8*i -: 8];
            fb[6 + i] = src[47-8*i -: 8];
        end
        {fb[12], fb[13]} = w12;
        {fb[14], fb[15]} = w14;
        {fb[16], fb[17]} = w16;
    endtask

    // Reference decode straight from the frame byte list.
    function automatic hdr_t ref_hdr();
        hdr_t        h;
        logic [15:0] tpid;
        h.dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
        h.src = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
        tpid  = {fb[12], fb[13]};
        if (tpid == 16'h8100) begin
            h.vlan = 1'b1; h.tci = {fb[14], fb[15]}; h.etype = {fb[16], fb[17]};
        end else begin
            h.vlan = 1'b0; h.tci = 16'h0000; h.etype = tpid;
        end
        return h;
    endfunction

    task automatic expect_frame(input bit is_hdr, input bit single, input hdr_t h);
        exp_starts++;
        if (is_hdr) begin
            exp_q.push_back(h);
            exp_sf++;
        end else begin
            exp_runts++;
            exp_sr++;
            if (single) exp_both++;
        end
    endtask

    // Entered and left at posedge+1; beats beyond nsend are never driven.
    task automatic send_frame(input int nbeats, input int nsend, input int gap_max);
        bit ok;
        for (int b = 0; b < nsend; b++) begin
            if (gap_max > 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
            s_tvalid = 1'b1;
            s_tlast  = (b == nbeats - 1);
            for (int k = 0; k < 8; k++) s_tdata[8*k +: 8] = fb[8*b + k];
            ok = 1'b0;
            for (int w = 0; w < 200 && !ok; w++) begin
                @(negedge clk);
                ok = s_tready;
                if (!ok) begin @(posedge clk); #1; end
            end
            if (!ok) begin
                n_checks++;
                $display("FAIL send_timeout: s_tready stayed 0 at beat %0d", b);
                s_tvalid = 1'b0; s_tlast = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int w = 0; w < 300; w++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !hdr_valid) return;
        end
        n_checks++;
        $display("FAIL drain_timeout: %0d headers never delivered, hdr_valid=%0b", exp_q.size(), hdr_valid);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_starts"}, 64'(seen_starts), 64'(exp_starts));
        check({tag, "_runts"},  64'(seen_runts),  64'(exp_runts));
        check({tag, "_both"},   64'(seen_both),   64'(exp_both));
        check({tag, "_stat_frames"}, 64'(stat_frames), 64'(stat_exp(exp_sf)));
        check({tag, "_stat_runts"},  64'(stat_runts),  64'(stat_exp(exp_sr)));
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (rand_ready) hdr_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: header scoreboard and event counters.
    always @(negedge clk) begin
        hdr_t e;
        if (rst_n) begin
            if (frame_start) begin seen_starts++; start_cyc.push_back(cyc); end
            if (err_runt) seen_runts++;
            if (frame_start && err_runt) seen_both++;
            if (hdr_valid && hdr_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_hdr: got dst %0h, expected no header", hdr_dst_mac);
                end else begin
                    e = exp_q.pop_front();
                    check("hdr_dst",  64'(hdr_dst_mac),    64'(e.dst));
                    check("hdr_src",  64'(hdr_src_mac),    64'(e.src));
                    check("hdr_vlan", 64'(hdr_vlan_valid), 64'(e.vlan));
                    check("hdr_tci",  64'(hdr_vlan_tci),   64'(e.tci));
                    check("hdr_type", 64'(hdr_ethertype),  64'(e.etype));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        vec_t v;
        hdr_t h, ha;
        bit   got;
        int   n;

        vecs[0] = '{"untagged", 48'h001122334455, 48'h66778899AABB, 16'h0800, 16'h4500, 16'h0054, 3, 1'b1, 1'b0, 16'h0000, 16'h0800};
        vecs[1] = '{"tagged5",  48'h0A0B0C0D0E0F, 48'h102030405060, 16'h8100, 16'h6064, 16'h86DD, 5, 1'b1, 1'b1, 16'h6064, 16'h86DD};
        vecs[2] = '{"runt2",    48'hFFFFFFFFFFFF, 48'h000000000001, 16'h0800, 16'h1111, 16'h2222, 2, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[3] = '{"runt1",    48'h123456789ABC, 48'hDEF012345678, 16'h8100, 16'h0001, 16'h0800, 1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{"tagged3",  48'h01005E000001, 48'hAABBCCDDEEFF, 16'h8100, 16'hE00A, 16'h88F7, 3, 1'b1, 1'b1, 16'hE00A, 16'h88F7};
        vecs[5] = '{"tpid9100", 48'h020000000002, 48'h020000000003, 16'h9100, 16'h0123, 16'h0800, 3, 1'b1, 1'b0, 16'h0000, 16'h9100};
        vecs[6] = '{"long6",    48'hCAFEBABE0001, 48'hCAFEBABE0002, 16'h0806, 16'h0001, 16'h0800, 6, 1'b1, 1'b0, 16'h0000, 16'h0806};

        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; hdr_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready",      64'(s_tready),      64'd1);
        check("rst_hdr_valid",   64'(hdr_valid),     64'd0);
        check("rst_frame_start", 64'(frame_start),   64'd0);
        check("rst_in_header",   64'(in_header),     64'd0);
        check("rst_err_runt",    64'(err_runt),      64'd0);
        check("rst_dst",         64'(hdr_dst_mac),   64'd0);
        check("rst_type",        64'(hdr_ethertype), 64'd0);
        check("rst_stat_frames", 64'(stat_frames),   64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            build(v.dst, v.src, v.w12, v.w14, v.w16);
            h = '{v.dst, v.src, v.exp_vlan, v.exp_tci, v.exp_type};
            expect_frame(v.exp_hdr, v.nbeats == 1, h);
            send_frame(v.nbeats, v.nbeats, 0);
            if (v.exp_hdr && v.nbeats == 3) begin
                @(negedge clk);
                check({v.name, "_latency"}, 64'(hdr_valid), 64'd1);
                @(posedge clk); #1;
            end else if (!v.exp_hdr) begin
                @(negedge clk);
                check({v.name, "_err_runt"}, 64'(err_runt), 64'd1);
                check({v.name, "_no_hdr"},   64'(hdr_valid), 64'd0);
                @(posedge clk); #1;
            end
            drain();
            check_counts(v.name);
        end

        // Back-to-back 3-beat frames: frame_start every 3 cycles.
        start_cyc.delete();
        for (int f = 0; f < 3; f++) begin
            build({16'h0200, 32'($urandom)}, {16'h0400, 32'($urandom)}, 16'h0800, 16'($urandom), 16'($urandom));
            expect_frame(1'b1, 1'b0, ref_hdr());
            send_frame(3, 3, 0);
        end
        drain();
        check("b2b_start_count", 64'(start_cyc.size()), 64'd3);
        if (start_cyc.size() == 3) begin
            check("b2b_gap0", 64'(start_cyc[1] - start_cyc[0]), 64'd3);
            check("b2b_gap1", 64'(start_cyc[2] - start_cyc[1]), 64'd3);
        end
        check_counts("b2b");

        // Output slot held full: second frame stalls at its second beat.
        hdr_ready = 1'b0;
        build(48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 16'h0000, 16'h0000);
        ha = ref_hdr();
        expect_frame(1'b1, 1'b0, ha);
        send_frame(3, 3, 0);
        @(negedge clk);
        check("bp_hold_valid", 64'(hdr_valid), 64'd1);
        @(posedge clk); #1;
        build(48'hC1C2C3C4C5C6, 48'hD1D2D3D4D5D6, 16'h8100, 16'h0ABC, 16'h0806);
        expect_frame(1'b1, 1'b0, ref_hdr());
        fork
            send_frame(4, 4, 0);
            begin
                got = 1'b0;
                for (int w = 0; w < 20 && !got; w++) begin @(negedge clk); got = frame_start; end
                if (!got) begin
                    n_checks++;
                    $display("FAIL bp_start_timeout: frame_start never seen");
                end else begin
                    check("bp_tready_low", 64'(s_tready),  64'd0);
                    check("bp_in_header",  64'(in_header), 64'd1);
                end
                repeat (3) @(negedge clk);
                check("bp_tready_still_low", 64'(s_tready),    64'd0);
                check("bp_fields_stable",    64'(hdr_dst_mac), 64'(ha.dst));
                @(posedge clk); #1;
                hdr_ready = 1'b1;
            end
        join
        drain();
        check_counts("bp");

        // Reset in the middle of a header: that frame is abandoned.
        build(48'hEEEEEEEEEEEE, 48'hDDDDDDDDDDDD, 16'h0800, 16'h0000, 16'h0000);
        exp_starts++;
        send_frame(3, 2, 0);
        rst_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_mid_in_header", 64'(in_header), 64'd0);
        check("rst_mid_tready",    64'(s_tready),  64'd1);
        rst_n  = 1'b1;
        exp_sf = 0;
        exp_sr = 0;
        build(48'h0F0E0D0C0B0A, 48'h090807060504, 16'h86DD, 16'h0000, 16'h0000);
        expect_frame(1'b1, 1'b0, ref_hdr());
        send_frame(4, 4, 1);
        drain();
        check_counts("rst");

        // Randomized frames with random backpressure on the header output.
        rand_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 6);
            build({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                  ($urandom_range(0, 1) != 0) ? 16'h8100 : 16'($urandom),
                  16'($urandom), 16'($urandom));
            expect_frame(n >= 3, n == 1, ref_hdr());
            send_frame(n, n, 2);
        end
        rand_ready = 1'b0;
        hdr_ready  = 1'b1;
        drain();
        check_counts("rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eth_hdr_extract.md
ETH_HDR_EXTRACT -- requirements
Module: eth_hdr_extract

Interface
REQ-001 Parameter DATA_WIDTH, default 64; stream width in bits; only 64 is supported.
REQ-002 Parameter HEADER_BYTES, default 18; header bytes captured (14 + optional 802.1Q tag).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 s_tdata  input  DATA_WIDTH  frame beat; byte n of beat in bits [8n+7:8n].
REQ-006 s_tvalid / s_tlast  input  1 each  beat valid / last beat of frame.
REQ-007 s_tready  output  1  beat accepted when s_tvalid && s_tready.
REQ-008 frame_start  output  1  one-cycle pulse on acceptance of first beat of a frame.
REQ-009 in_header  output  1  high while header beats are being collected.
REQ-010 hdr_valid  output  1 / hdr_ready  input  1  header output handshake.
REQ-011 hdr_dst_mac, hdr_src_mac  output  48 each; hdr_vlan_valid  output  1; hdr_vlan_tci  output  16; hdr_ethertype  output  16.
REQ-012 err_runt  output  1  one-cycle pulse when a frame ends before the header completes.
REQ-013 stat_frames, stat_runts  output  32 each  statistics counters.

Function
REQ-014 States: IDLE, HDR, SKIP; a frame's first accepted beat leaves IDLE.
REQ-015 HDR_BEATS = ceil(HEADER_BYTES/8) = 3; beat counter counts accepted header beats 0..2.
REQ-016 IDLE: accepted beat -> frame_start pulse next cycle, beat stored at buffer bytes 0-7, go HDR (or runt if s_tlast).
REQ-017 HDR: accepted beats stored at bytes 8-15, 16-23; in_header = 1 in HDR and registered 1 cycle after first-beat acceptance.
REQ-018 Header completes on acceptance of beat index 2; next cycle hdr_valid = 1 with decoded fields; state -> SKIP, or IDLE if that beat has s_tlast.
REQ-019 Decode: dst = bytes 0-5, src = bytes 6-11, byte 0 is MSB of each MAC; TPID = {byte12,byte13}.
REQ-020 TPID == 16'h8100: vlan_valid = 1, tci = {byte14,byte15}, ethertype = {byte16,byte17}; else vlan_valid = 0, tci = 0, ethertype = TPID.
REQ-021 SKIP: s_tready = 1, beats discarded until s_tlast accepted, then IDLE.
REQ-022 hdr_valid holds, fields stable, until cycle after hdr_valid && hdr_ready; then hdr_valid = 0.
REQ-023 s_tready = 0 only when state == HDR and hdr_valid == 1 and hdr_ready == 0 (output slot occupied); 1 otherwise.
REQ-024 Simultaneous header completion and hdr_ready acceptance of previous header: new header loads, hdr_valid stays 1, no bubble.
REQ-025 s_tlast accepted in IDLE or HDR before beat index 2: err_runt pulse next cycle, no hdr_valid, buffer discarded, -> IDLE.
REQ-026 Single-beat frame in IDLE: frame_start and err_runt pulse in same cycle.
REQ-027 Latency: last header beat acceptance to hdr_valid = 1 cycle.

Reset
REQ-028 rst_n low at a clock edge: state IDLE, beat counter 0, hdr_valid, frame_start, in_header, err_runt = 0, all field outputs 0, counters 0.
REQ-029 s_tready = 1 during and after reset; a frame in progress at reset is abandoned, not resumed.

Configuration
REQ-030 Macro ETH_HDR_STATS_EN: defined -> stat_frames increments on each hdr_valid load, stat_runts on each err_runt, both saturating at 32'hFFFF_FFFF.
REQ-031 Macro undefined -> stat ports present and driven constant 0, no counter flops.

Structure
REQ-032 Package eth_parser_pkg holds eth_hdr_t struct (dst, src, vlan_valid, tci, ethertype), TPID_VLAN = 16'h8100, state enum.
REQ-033 Sub-module eth_hdr_decode: combinational 24-byte buffer -> eth_hdr_t; registered in eth_hdr_extract.

Verification
REQ-034 Untagged 3-beat frame, dst 00:11:22:33:44:55, src 66:77:88:99:AA:BB, type 0800, hdr_ready=1 -> hdr_valid 1 cycle after beat 3, vlan_valid=0, ethertype=16'h0800.
REQ-035 Tagged 5-beat frame, TPID 8100, TCI 0x6064, type 86DD -> vlan_valid=1, tci=16'h6064, ethertype=16'h86DD, beats 4-5 drained.
REQ-036 2-beat frame, s_tlast on beat 2 -> err_runt pulse, no hdr_valid, stat_runts=1 (macro on).
REQ-037 hdr_ready=0 held, second frame sent -> s_tready low at 2nd frame beat 2, no data lost; hdr_ready=1 -> second header loads.
REQ-038 rst_n low during HDR of frame 1, then clean frame 2 -> only frame 2 header reported, stat_frames=1.
REQ-039 Back-to-back 3-beat frames, tlast on beat 3, hdr_ready=1 -> frame_start pulses every 3 cycles, hdr_valid each frame.
